// File: rtl/shift_add_multiplier_param.sv
// Sequential shift-and-add multiplier: one multiplier bit per clock, unsigned or two's-complement per operation.
// Optional macro SHIFT_ADD_EARLY_TERM_EN finishes as soon as the unconsumed multiplier bits are all zero.
module shift_add_multiplier_param #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   q,
    output logic [2*WIDTH-1:0] result,
    output logic               busy,
    output logic               done
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH:0]     a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               mode_q, mode_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WIDTH+1:0]   a_ext;
    logic [WIDTH+1:0]   addend_ext;
    logic [WIDTH+1:0]   sum;
    logic [WIDTH:0]     a_step;
    logic [WIDTH-1:0]   q_step;
    logic [CNT_W-1:0]   cnt_step;
    logic               step_done;
    logic [2*WIDTH-1:0] prod_full;
`ifdef SHIFT_ADD_EARLY_TERM_EN
    logic [WIDTH-1:0]   rem_mask;
    logic [2*WIDTH:0]   aq_full;
`endif

    // One iteration: sum is two bits wider than B so carry (unsigned) or sign (signed) is exact.
    always_comb begin
        a_ext      = {mode_q & a_q[WIDTH], a_q};
        addend_ext = '0;
        if (q_q[0]) begin
            addend_ext = {{2{mode_q & b_q[WIDTH-1]}}, b_q};
            // The multiplier MSB carries negative weight in two's complement.
            if (mode_q && (cnt_q == CNT_W'(1))) begin
                addend_ext = -addend_ext;
            end
        end
        sum      = a_ext + addend_ext;
        a_step   = sum[WIDTH+1:1];
        q_step   = {sum[0], q_q[WIDTH-1:1]};
        cnt_step = cnt_q - CNT_W'(1);
`ifdef SHIFT_ADD_EARLY_TERM_EN
        // Low cnt_step bits of q_step are the multiplier bits not yet consumed.
        rem_mask  = ~({WIDTH{1'b1}} << cnt_step);
        step_done = ((q_step & rem_mask) == '0);
        aq_full   = {a_step, q_step};
        if (mode_q) begin
            prod_full = (2*WIDTH)'($signed(aq_full) >>> cnt_step);
        end else begin
            prod_full = (2*WIDTH)'(aq_full >> cnt_step);
        end
`else
        step_done = (cnt_step == '0);
        prod_full = {a_step[WIDTH-1:0], q_step};
`endif
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        q_d      = q_q;
        mode_d   = mode_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    b_d     = b;
                    q_d     = q;
                    mode_d  = signed_mode;
                    a_d     = '0;
                    cnt_d   = CNT_W'(WIDTH);
                    busy_d  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                a_d   = a_step;
                q_d   = q_step;
                cnt_d = cnt_step;
                // Result and done are registered on entry so both are visible during DONE.
                if (step_done) begin
                    result_d = prod_full;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            q_q      <= '0;
            mode_q   <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            q_q      <= q_d;
            mode_q   <= mode_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign result = result_q;
    assign busy   = busy_q;
    assign done   = done_q;
endmodule

// File: tb/tb_shift_add_multiplier_param.sv
// Self-checking bench: WIDTH=8 directed operations plus a WIDTH=16 randomized sweep against a product/latency model.
module tb_shift_add_multiplier_param;
`ifdef SHIFT_ADD_EARLY_TERM_EN
    localparam bit ET = 1'b1;
`else
    localparam bit ET = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start8 = 1'b0, s8 = 1'b0;
    logic [7:0]  b8 = '0, q8 = '0;
    logic [15:0] r8;
    logic        busy8, done8;
    logic        start16 = 1'b0, s16 = 1'b0;
    logic [15:0] b16 = '0, q16 = '0;
    logic [31:0] r16;
    logic        busy16, done16;

    always #5 clk = ~clk;

    shift_add_multiplier_param #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(s8), .b(b8), .q(q8),
        .result(r8), .busy(busy8), .done(done8)
    );
    shift_add_multiplier_param #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .signed_mode(s16), .b(b16), .q(q16),
        .result(r16), .busy(busy16), .done(done16)
    );

    int     errors = 0;
    int     checks = 0;
    int     cyc = 0;
    bit     m_busy [2];
    int     m_done_cyc [2];
    int     m_acc_cyc [2];
    longint m_res [2];
    longint m_pend [2];
    int     accepted16 = 0;
    bit     lit_on = 1'b0;
    longint lit_res = 0;
    int     lit_lat = 0;
    int     tmo_cnt = 0;
    int     tmo_seen = 0;

    function automatic longint sx(int w, bit s, longint v);
        if (s && v[w-1]) return v - (longint'(1) << w);
        return v;
    endfunction

    function automatic longint ref_prod(int w, bit s, longint bv, longint qv);
        return (sx(w, s, bv) * sx(w, s, qv)) & ((longint'(1) << (2 * w)) - 1);
    endfunction

    // Number of multiplier bits that must be processed before done.
    function automatic int ref_steps(int w, longint qv);
        int n = 0;
        if (!ET) return w;
        for (int i = 0; i < w; i++) if (qv[i]) n = i + 1;
        return (n == 0) ? 1 : n;
    endfunction

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_edge(int i, int w, bit st, bit s, longint bv, longint qv);
        bit was = m_busy[i];
        if (rst) begin
            m_busy[i] = 1'b0;
            m_res[i]  = 0;
            return;
        end
        if (was && cyc > m_done_cyc[i]) m_busy[i] = 1'b0;
        if (!was && st) begin
            m_busy[i]     = 1'b1;
            m_acc_cyc[i]  = cyc;
            m_done_cyc[i] = cyc + ref_steps(w, qv);
            m_pend[i]     = ref_prod(w, s, bv, qv);
            if (i == 1) accepted16++;
        end
        if (m_busy[i] && cyc == m_done_cyc[i]) m_res[i] = m_pend[i];
    endtask

    task automatic model_check(int i, string tag, bit busy, bit done, longint res);
        if (rst) begin
            m_busy[i] = 1'b0;
            m_res[i]  = 0;
        end
        chk({tag, "_busy"}, busy, m_busy[i]);
        chk({tag, "_done"}, done, m_busy[i] && cyc == m_done_cyc[i]);
        chk({tag, "_result"}, res, m_res[i]);
        if (i == 0 && lit_on && done) begin
            chk("lit_result", res, lit_res);
            chk("lit_latency", cyc - m_acc_cyc[0] + 1, lit_lat);
        end
    endtask

    // Model advances on rising edges; outputs are compared on falling edges.
    always @(posedge clk or negedge clk) begin
        if (clk) begin
            cyc++;
            model_edge(0, 8, start8, s8, b8, q8);
            model_edge(1, 16, start16, s16, b16, q16);
        end else begin
            model_check(0, "w8", busy8, done8, r8);
            model_check(1, "w16", busy16, done16, r16);
            chk("timeout", tmo_cnt, tmo_seen);
            tmo_seen = tmo_cnt;
        end
    end

    task automatic op8(bit s, logic [7:0] bv, logic [7:0] qv, longint exp, int lat, bit noise);
        bit seen = 1'b0;
        @(posedge clk); #1;
        s8 = s; b8 = bv; q8 = qv; start8 = 1'b1;
        lit_res = exp; lit_lat = lat; lit_on = 1'b1;
        @(posedge clk); #1;
        if (noise) begin
            repeat (3) begin
                s8 = ~s8; b8 = 8'($urandom); q8 = 8'($urandom);
                @(posedge clk); #1;
            end
        end
        start8 = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = done8;
        end
        if (!seen) tmo_cnt++;
        @(posedge clk); #1;
        lit_on = 1'b0;
    endtask

    function automatic logic [15:0] pick16();
        case ($urandom_range(0, 5))
            0: return 16'h8000;
            1: return 16'hFFFF;
            2: return 16'($urandom_range(0, 15));
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        op8(1'b0, 8'd255, 8'd255, 64'hFE01, 9, 1'b0);
        op8(1'b1, 8'hFD, 8'h05, 64'hFFF1, ET ? 4 : 9, 1'b0);
        op8(1'b1, 8'h05, 8'hFD, 64'hFFF1, 9, 1'b0);
        op8(1'b1, 8'h80, 8'h80, 64'h4000, 9, 1'b0);
        op8(1'b0, 8'd200, 8'd1, 64'd200, ET ? 2 : 9, 1'b0);
        op8(1'b0, 8'd200, 8'd0, 64'd0, ET ? 2 : 9, 1'b0);
        op8(1'b1, 8'h7F, 8'h81, 64'hC0FF, 9, 1'b1);
        op8(1'b0, 8'hFF, 8'h02, 64'h01FE, ET ? 3 : 9, 1'b0);

        // Abort an operation with reset in its fourth busy cycle.
        @(posedge clk); #1;
        s8 = 1'b0; b8 = 8'h5A; q8 = 8'hC3; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (12) @(posedge clk);
        op8(1'b0, 8'd12, 8'd11, 64'd132, ET ? 5 : 9, 1'b0);

        // Randomized sweep with start held mostly high so the DONE-cycle start is exercised.
        for (int c = 0; c < 40000 && accepted16 < 1000; c++) begin
            @(negedge clk);
            start16 = ($urandom_range(0, 3) != 0);
            s16     = 1'($urandom_range(0, 1));
            b16     = pick16();
            q16     = pick16();
        end
        if (accepted16 < 1000) tmo_cnt++;
        @(negedge clk);
        start16 = 1'b0;
        repeat (25) @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
